// File: rtl/camera_pkg.sv
// Shared types for the pixel capture path: sequencer states, the crop window
// record and small window arithmetic helpers.
package camera_pkg;

    // Window fields are held at a fixed width wide enough for any supported
    // coordinate width; modules zero-extend their X_W/Y_W values into it.
    localparam int WIN_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SYNC     = 2'd1,
        WAIT_SOF = 2'd2,
        ACTIVE   = 2'd3
    } capture_state_t;

    typedef struct packed {
        logic [WIN_W-1:0] xs;
        logic [WIN_W-1:0] xe;
        logic [WIN_W-1:0] ys;
        logic [WIN_W-1:0] ye;
        logic [1:0]       sub;
    } window_t;

    function automatic logic window_empty(input window_t w);
        return (w.xe <= w.xs) || (w.ye <= w.ys);
    endfunction

    // Output extent along one axis; an inverted window reports zero rather
    // than a wrapped difference.
    function automatic logic [WIN_W-1:0] span(input logic [WIN_W-1:0] lo,
                                              input logic [WIN_W-1:0] hi,
                                              input logic [1:0]       sub);
        if (hi <= lo)
            return '0;
        return (hi - lo) >> sub;
    endfunction

endpackage

// File: rtl/pixel_position_counter.sv
// Frame/line edge detection and saturating pixel coordinates.
// x_pos/y_pos are the coordinates of the pixel present on the inputs this
// cycle (zero on the first pixel of a line / first line of a frame).
module pixel_position_counter #(
    parameter int X_W = 11,
    parameter int Y_W = 10
) (
    input  logic           clock_pixel_in,
    input  logic           reset_pixel_in,
    input  logic           frame_valid_in,
    input  logic           line_valid_in,
    output logic           frame_rise,
    output logic           frame_fall,
    output logic           line_valid,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos
);

    logic           frame_q;
    logic           line_q;
    logic           line_rise;
    logic           line_fall;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;

    // A line strobe outside a frame is treated as if it never happened.
    assign line_valid = line_valid_in & frame_valid_in;
    assign frame_rise = frame_valid_in & ~frame_q;
    assign frame_fall = ~frame_valid_in & frame_q;
    assign line_rise  = line_valid & ~line_q;
    assign line_fall  = ~line_valid & line_q;

    assign x_pos = line_rise  ? '0 : x_q;
    assign y_pos = frame_rise ? '0 : y_q;

    // Delayed valids for edge detection; x/y advance and saturate at all-ones.
    always_ff @(posedge clock_pixel_in or posedge reset_pixel_in) begin
        if (reset_pixel_in) begin
            frame_q <= 1'b0;
            line_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            frame_q <= frame_valid_in;
            line_q  <= line_valid;
            if (line_valid && (x_pos != '1))
                x_q <= x_pos + X_W'(1);
            else if (line_valid)
                x_q <= x_pos;
            if (frame_rise)
                y_q <= '0;
            else if (line_fall && (y_q != '1))
                y_q <= y_q + Y_W'(1);
        end
    end

endmodule

// File: rtl/capture_window.sv
// Capture sequencer and runtime crop window on the pixel stream.
// Optional feature macro: CAPTURE_SUBSAMPLE_EN adds subsample_in and 2**sub
// decimation on both axes; without it no decimation logic is built.
//
// state    | meaning
// IDLE     | not capturing; start requests are evaluated here
// SYNC     | armed, waiting for the current frame (if any) to end
// WAIT_SOF | waiting for the rising edge of frame_valid_in
// ACTIVE   | forwarding in-window pixels of the current frame
module capture_window
    import camera_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int PIXEL_W  = 10,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic                          clock_pixel_in,
    input  logic                          reset_pixel_in,
    input  logic                          capture_start_in,
    input  logic                          capture_abort_in,
    input  logic [7:0]                    frame_count_in,
    input  logic [X_W-1:0]                x_start_in,
    input  logic [X_W-1:0]                x_end_in,
    input  logic [Y_W-1:0]                y_start_in,
    input  logic [Y_W-1:0]                y_end_in,
`ifdef CAPTURE_SUBSAMPLE_EN
    input  logic [1:0]                    subsample_in,
`endif
    input  logic                          frame_valid_in,
    input  logic                          line_valid_in,
    input  logic [CHANNELS*PIXEL_W-1:0]   data_in,
    output logic [CHANNELS*PIXEL_W-1:0]   data_out,
    output logic                          line_valid_out,
    output logic                          frame_valid_out,
    output logic [X_W-1:0]                x_size_out,
    output logic [Y_W-1:0]                y_size_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          error_out,
    output logic [7:0]                    frames_done_out
);

    capture_state_t state_q, state_d;
    window_t        win_in, shadow_q, win_cur;

    logic           frame_rise, frame_fall, line_valid;
    logic [X_W-1:0] x_pos;
    logic [Y_W-1:0] y_pos;
    logic [WIN_W-1:0] x_w, y_w;
    logic [1:0]     sub_in;
    logic           active_now, in_window, phase_ok, keep;
    logic           start_ok, start_err, frame_end, finish;

`ifdef CAPTURE_SUBSAMPLE_EN
    assign sub_in = subsample_in;
`else
    assign sub_in = 2'd0;
`endif

    assign win_in = '{xs:  WIN_W'(x_start_in),
                      xe:  WIN_W'(x_end_in),
                      ys:  WIN_W'(y_start_in),
                      ye:  WIN_W'(y_end_in),
                      sub: sub_in};

    pixel_position_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_position (
        .clock_pixel_in (clock_pixel_in),
        .reset_pixel_in (reset_pixel_in),
        .frame_valid_in (frame_valid_in),
        .line_valid_in  (line_valid_in),
        .frame_rise     (frame_rise),
        .frame_fall     (frame_fall),
        .line_valid     (line_valid),
        .x_pos          (x_pos),
        .y_pos          (y_pos)
    );

    // The SOF cycle already belongs to the new frame, so it sees the freshly
    // sampled window and counts as captured if WAIT_SOF saw the edge.
    assign win_cur    = frame_rise ? win_in : shadow_q;
    assign active_now = (state_q == ACTIVE) || ((state_q == WAIT_SOF) && frame_rise);
    assign x_w        = WIN_W'(x_pos);
    assign y_w        = WIN_W'(y_pos);

    // Pixel keep decision: window compare plus optional decimation phase.
    always_comb begin
        in_window = (x_w >= win_cur.xs) && (x_w < win_cur.xe) &&
                    (y_w >= win_cur.ys) && (y_w < win_cur.ye);
`ifdef CAPTURE_SUBSAMPLE_EN
        phase_ok  = (((x_w | y_w) & ((WIN_W'(1) << win_cur.sub) - WIN_W'(1))) == '0);
`else
        phase_ok  = 1'b1;
`endif
        keep      = active_now && line_valid && in_window && phase_ok && !capture_abort_in;
    end

    // Next-state logic; abort overrides everything, including a same-cycle start.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_err = 1'b0;
        frame_end = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_start_in && !capture_abort_in) begin
                    if (window_empty(win_in)) begin
                        start_err = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = SYNC;
                    end
                end
            end
            SYNC: begin
                if (capture_abort_in)
                    state_d = IDLE;
                else if (!frame_valid_in)
                    state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (capture_abort_in)
                    state_d = IDLE;
                else if (frame_rise)
                    state_d = ACTIVE;
            end
            ACTIVE: begin
                if (capture_abort_in) begin
                    state_d = IDLE;
                end else if (frame_fall) begin
                    frame_end = 1'b1;
                    if ((frame_count_in != 8'd0) && (frames_done_out + 8'd1 == frame_count_in)) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_SOF;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, shadow window, frame counter and registered outputs.
    always_ff @(posedge clock_pixel_in or posedge reset_pixel_in) begin
        if (reset_pixel_in) begin
            state_q         <= IDLE;
            shadow_q        <= '0;
            frames_done_out <= 8'd0;
            data_out        <= '0;
            line_valid_out  <= 1'b0;
            frame_valid_out <= 1'b0;
            done_out        <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok || frame_rise)
                shadow_q <= win_in;
            if (start_ok)
                frames_done_out <= 8'd0;
            else if (frame_end)
                frames_done_out <= frames_done_out + 8'd1;
            if (keep)
                data_out <= data_in;
            line_valid_out  <= keep;
            frame_valid_out <= active_now && frame_valid_in && !capture_abort_in;
            done_out        <= finish;
            error_out       <= start_err;
        end
    end

    assign busy_out   = (state_q != IDLE);
    assign x_size_out = X_W'(span(shadow_q.xs, shadow_q.xe, shadow_q.sub));
    assign y_size_out = Y_W'(span(shadow_q.ys, shadow_q.ye, shadow_q.sub));

endmodule

// File: tb/tb_capture_window.sv
// Self-checking bench for capture_window. Frames are generated with random
// pixel data; a frame-level model decides which frames are captured and
// which pixels fall inside the window, and queues the expected output.
// Define CAPTURE_SUBSAMPLE_EN to include the decimation cases.
`timescale 1ns/1ps
module tb_capture_window;

    localparam int CHANNELS = 1;
    localparam int PIXEL_W  = 10;
    localparam int X_W      = 11;
    localparam int Y_W      = 10;
    localparam int D_W      = CHANNELS * PIXEL_W;

    logic           clock_pixel_in   = 1'b0;
    logic           reset_pixel_in   = 1'b1;
    logic           capture_start_in = 1'b0;
    logic           capture_abort_in = 1'b0;
    logic [7:0]     frame_count_in   = 8'd1;
    logic [X_W-1:0] x_start_in       = '0;
    logic [X_W-1:0] x_end_in         = '0;
    logic [Y_W-1:0] y_start_in       = '0;
    logic [Y_W-1:0] y_end_in         = '0;
    logic [1:0]     subsample_in     = 2'd0;
    logic           frame_valid_in   = 1'b0;
    logic           line_valid_in    = 1'b0;
    logic [D_W-1:0] data_in          = '0;
    logic [D_W-1:0] data_out;
    logic           line_valid_out, frame_valid_out;
    logic [X_W-1:0] x_size_out;
    logic [Y_W-1:0] y_size_out;
    logic           busy_out, done_out, error_out;
    logic [7:0]     frames_done_out;

    capture_window #(
        .CHANNELS (CHANNELS),
        .PIXEL_W  (PIXEL_W),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) dut (
        .clock_pixel_in   (clock_pixel_in),
        .reset_pixel_in   (reset_pixel_in),
        .capture_start_in (capture_start_in),
        .capture_abort_in (capture_abort_in),
        .frame_count_in   (frame_count_in),
        .x_start_in       (x_start_in),
        .x_end_in         (x_end_in),
        .y_start_in       (y_start_in),
        .y_end_in         (y_end_in),
`ifdef CAPTURE_SUBSAMPLE_EN
        .subsample_in     (subsample_in),
`endif
        .frame_valid_in   (frame_valid_in),
        .line_valid_in    (line_valid_in),
        .data_in          (data_in),
        .data_out         (data_out),
        .line_valid_out   (line_valid_out),
        .frame_valid_out  (frame_valid_out),
        .x_size_out       (x_size_out),
        .y_size_out       (y_size_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .error_out        (error_out),
        .frames_done_out  (frames_done_out)
    );

    always #5 clock_pixel_in = ~clock_pixel_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    logic [D_W-1:0] prev_in;
    logic [D_W-1:0] got_q[$];
    logic [D_W-1:0] exp_q[$];
    logic           fvo_q = 1'b0;
    int lat_bad = 0, done_cnt = 0, err_cnt = 0, fvo_frames = 0;

    always @(posedge clock_pixel_in) prev_in <= data_in;

    always @(negedge clock_pixel_in) begin
        if (!reset_pixel_in) begin
            if (line_valid_out) begin
                got_q.push_back(data_out);
                if (data_out !== prev_in) lat_bad <= lat_bad + 1;
            end
            if (done_out)  done_cnt <= done_cnt + 1;
            if (error_out) err_cnt  <= err_cnt + 1;
            if (frame_valid_out && !fvo_q) fvo_frames <= fvo_frames + 1;
            fvo_q <= frame_valid_out;
        end
    end

    // ---------------- frame-level reference model ----------------
    bit armed    = 1'b0;
    int m_frames = 0;
    int exp_done = 0;
    int exp_err  = 0;
    int rw_xs    = 0, rw_xe = 0;

    function automatic int cur_sub();
`ifdef CAPTURE_SUBSAMPLE_EN
        return int'(subsample_in);
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clock_pixel_in);
        #1;
    endtask

    task automatic model_start();
        if (!armed) begin
            if (x_end_in <= x_start_in || y_end_in <= y_start_in) begin
                exp_err++;
            end else begin
                armed    = 1'b1;
                m_frames = 0;
            end
        end
    endtask

    task automatic do_start();
        capture_start_in = 1'b1;
        model_start();
        tick();
        capture_start_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_abort();
        capture_abort_in = 1'b1;
        armed = 1'b0;
        tick();
        capture_abort_in = 1'b0;
        tick();
    endtask

    task automatic drive_frame(input int w, input int h, input int start_line = -1,
                               input int abort_line = -1, input int rewrite_line = -1);
        bit cap;
        int wxs, wxe, wys, wye, sub, mask;
        cap  = armed;
        wxs  = int'(x_start_in);
        wxe  = int'(x_end_in);
        wys  = int'(y_start_in);
        wye  = int'(y_end_in);
        sub  = cur_sub();
        mask = (1 << sub) - 1;
        frame_valid_in = 1'b1;
        tick();
        tick();
        for (int y = 0; y < h; y++) begin
            if (y == start_line) begin
                capture_start_in = 1'b1;
                model_start();
            end
            if (y == rewrite_line) begin
                x_start_in = X_W'(rw_xs);
                x_end_in   = X_W'(rw_xe);
            end
            line_valid_in = 1'b1;
            for (int x = 0; x < w; x++) begin
                data_in = D_W'($urandom);
                if (y == abort_line && x == w / 2) begin
                    capture_abort_in = 1'b1;
                    armed = 1'b0;
                    cap   = 1'b0;
                end
                if (cap && x >= wxs && x < wxe && y >= wys && y < wye &&
                    (x & mask) == 0 && (y & mask) == 0)
                    exp_q.push_back(data_in);
                tick();
                capture_start_in = 1'b0;
                if (capture_abort_in) begin
                    check_value("abort_line_valid_out", line_valid_out, 0);
                    check_value("abort_frame_valid_out", frame_valid_out, 0);
                    check_value("abort_busy", busy_out, 0);
                    capture_abort_in = 1'b0;
                end
            end
            line_valid_in = 1'b0;
            repeat (3) tick();
        end
        frame_valid_in = 1'b0;
        if (cap) begin
            m_frames++;
            if (frame_count_in != 8'd0 && (m_frames % 256) == int'(frame_count_in)) begin
                armed = 1'b0;
                exp_done++;
            end
        end
        repeat (4) tick();
    endtask

    task automatic compare_pixels(input string tag);
        int bad;
        int n;
        bad = 0;
        check_value({tag, "_pixel_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check_value({tag, "_pixel_data"}, bad, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic set_window(input int xs, input int xe, input int ys, input int ye);
        x_start_in = X_W'(xs);
        x_end_in   = X_W'(xe);
        y_start_in = Y_W'(ys);
        y_end_in   = Y_W'(ye);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        repeat (3) tick();
        check_value("reset_outputs",
                    {data_out, line_valid_out, frame_valid_out, x_size_out, y_size_out,
                     busy_out, done_out, error_out, frames_done_out}, 0);
        reset_pixel_in = 1'b0;
        repeat (2) tick();

        // 1: basic 16x16 crop of a 20x20 frame
        set_window(2, 18, 2, 18);
        frame_count_in = 8'd1;
        do_start();
        check_value("t1_busy_after_start", busy_out, 1);
        drive_frame(20, 20);
        compare_pixels("t1");
        check_value("t1_x_size", x_size_out, 16);
        check_value("t1_y_size", y_size_out, 16);
        check_value("t1_done", done_cnt, exp_done);
        check_value("t1_frames_done", frames_done_out, 1);
        check_value("t1_captured_frames", fvo_frames, 1);
        check_value("t1_busy_end", busy_out, 0);
        check_value("t1_latency", lat_bad, 0);

        // 2: start in the middle of a frame; only the next full frame is taken
        drive_frame(20, 20, 7);
        check_value("t2_partial_none", got_q.size(), 0);
        drive_frame(20, 20);
        check_value("t2_first_pixel", (got_q.size() > 0) ? got_q[0] : '1, exp_q[0]);
        compare_pixels("t2");
        check_value("t2_done", done_cnt, exp_done);

        // 3: three frames, window narrowed during frame 2 takes effect on frame 3
        frame_count_in = 8'd3;
        do_start();
        drive_frame(20, 20);
        rw_xs = 0;
        rw_xe = 8;
        drive_frame(20, 20, -1, -1, 8);
        check_value("t3_x_size_shadowed", x_size_out, 16);
        check_value("t3_no_early_done", done_cnt, exp_done);
        drive_frame(20, 20);
        check_value("t3_x_size_new", x_size_out, 8);
        compare_pixels("t3");
        check_value("t3_done", done_cnt, exp_done);
        check_value("t3_frames_done", frames_done_out, 3);

        // 3b: continuous capture until abort
        set_window(2, 18, 2, 18);
        frame_count_in = 8'd0;
        do_start();
        repeat (4) drive_frame(20, 20);
        check_value("t3c_busy", busy_out, 1);
        check_value("t3c_frames_done", frames_done_out, 4);
        check_value("t3c_no_done", done_cnt, exp_done);
        do_abort();
        check_value("t3c_busy_after_abort", busy_out, 0);
        compare_pixels("t3c");

        // 4: abort on line 5, then start and abort together
        frame_count_in = 8'd1;
        do_start();
        drive_frame(20, 20, -1, 5);
        compare_pixels("t4");
        check_value("t4_no_done", done_cnt, exp_done);
        capture_start_in = 1'b1;
        capture_abort_in = 1'b1;
        tick();
        capture_start_in = 1'b0;
        capture_abort_in = 1'b0;
        tick();
        check_value("t4_start_abort_idle", busy_out, 0);
        drive_frame(20, 20);
        compare_pixels("t4b");
        check_value("t4b_no_error", err_cnt, exp_err);

        // 5: empty window is rejected; start while busy is ignored
        set_window(4, 4, 2, 18);
        do_start();
        check_value("t5_error", err_cnt, exp_err);
        check_value("t5_busy", busy_out, 0);
        set_window(2, 18, 2, 18);
        frame_count_in = 8'd2;
        do_start();
        drive_frame(20, 20);
        do_start();
        drive_frame(20, 20);
        compare_pixels("t5");
        check_value("t5_done", done_cnt, exp_done);
        check_value("t5_frames_done", frames_done_out, 2);
        check_value("t5_error_total", err_cnt, exp_err);

`ifdef CAPTURE_SUBSAMPLE_EN
        // 6: decimate by 2 on both axes
        subsample_in   = 2'd1;
        frame_count_in = 8'd1;
        do_start();
        drive_frame(20, 20);
        compare_pixels("t6");
        check_value("t6_x_size", x_size_out, 8);
        check_value("t6_y_size", y_size_out, 8);
        subsample_in = 2'd0;
`endif

        // 7: random windows and frame sizes
        for (int it = 0; it < 6; it++) begin
            int w, h, xs, xe, ys, ye;
            w  = $urandom_range(30, 8);
            h  = $urandom_range(16, 4);
            xs = $urandom_range(w - 2, 0);
            xe = $urandom_range(w + 2, xs + 1);
            ys = $urandom_range(h - 2, 0);
            ye = $urandom_range(h + 2, ys + 1);
            set_window(xs, xe, ys, ye);
`ifdef CAPTURE_SUBSAMPLE_EN
            subsample_in = 2'($urandom_range(2, 0));
`endif
            frame_count_in = 8'($urandom_range(2, 1));
            do_start();
            for (int f = 0; f < int'(frame_count_in); f++) drive_frame(w, h);
            compare_pixels($sformatf("t7_%0d", it));
            check_value($sformatf("t7_%0d_x_size", it), x_size_out, (xe - xs) >> cur_sub());
            check_value($sformatf("t7_%0d_done", it), done_cnt, exp_done);
            check_value($sformatf("t7_%0d_busy", it), busy_out, 0);
        end
        check_value("final_latency", lat_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
